lbp_host_mem: RTL

Memory-side responder for the LBP engine's gray-image read port and LBP result write port. Holds the 128x128 8-bit gray image, which a host streams in after reset. Serves the engine's `gray_req`/`gray_addr` reads with fixed one-cycle latency and captures `lbp_valid` writes into a result memory. Tracks write count and checksum, and exposes the results to the host once the engine raises `finish`.

---
 rtl/lbp_host_mem_if.sv | 37 +++
 rtl/lbp_host_mem.sv | 114 +++++++++++
 2 files changed

// File: rtl/lbp_host_mem_if.sv
// Bundle of host-load, engine read/write and host readback signals for lbp_host_mem.
// The slave side is the memory responder and the master side is the host or engine driving it.
interface lbp_host_mem_if #(
  parameter int ADDR_W = 14
);
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [7:0]        gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [15:0]       checksum;
  logic              err;

  modport master (
    output load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, rd_addr,
    input  load_ready, gray_ready, gray_data, rd_data,
           done, wr_count, checksum, err
  );

  modport slave (
    input  load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, rd_addr,
    output load_ready, gray_ready, gray_data, rd_data,
           done, wr_count, checksum, err
  );
endinterface

// File: rtl/lbp_host_mem.sv
// Image/result memory responder for the LBP engine: host image load, engine serve phase,
// then host readback of results once the engine signals finish.
module lbp_host_mem #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input logic           clk,
  input logic           reset,
  lbp_host_mem_if.slave bus
);

  typedef enum logic [1:0] {StLoad, StServe, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [15:0]       checksum_q, checksum_d;
  logic              err_q, err_d;
  logic [7:0]        gray_data_q;
  logic [7:0]        rd_data_q;

  logic [7:0]        image_q  [DEPTH];
  logic [7:0]        result_q [DEPTH];

  logic              image_we;
  logic              result_we;
  logic              gray_rd_en;
  logic              rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLoad;
      load_ptr_q  <= '0;
      wr_count_q  <= '0;
      checksum_q  <= '0;
      err_q       <= 1'b0;
      gray_data_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      wr_count_q <= wr_count_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
      if (gray_rd_en) gray_data_q <= image_q[bus.gray_addr];
      if (rd_en)      rd_data_q   <= result_q[bus.rd_addr];
    end
  end

  // Memory arrays deliberately carry no reset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (image_we)  image_q[load_ptr_q]   <= bus.load_data;
    if (result_we) result_q[bus.lbp_addr] <= bus.lbp_data;
  end

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    wr_count_d = wr_count_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    image_we   = 1'b0;
    result_we  = 1'b0;
    gray_rd_en = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      StLoad: begin
        if (bus.load_valid) begin
          image_we   = !reset;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_ptr_q == LastAddr) state_d = StServe;
        end
        if (bus.gray_req || bus.lbp_valid) err_d = 1'b1;
      end
      StServe: begin
        gray_rd_en = bus.gray_req;
        if (bus.lbp_valid) begin
          result_we  = !reset;
          checksum_d = checksum_q + {8'h00, bus.lbp_data};
          if (wr_count_q != CountMax) wr_count_d = wr_count_q + 1'b1;
        end
        if (bus.finish) state_d = StDone;
        if (bus.load_valid) err_d = 1'b1;
      end
      StDone: begin
        rd_en = 1'b1;
        if (bus.load_valid || bus.gray_req || bus.lbp_valid) err_d = 1'b1;
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    bus.load_ready = 1'b0;
    bus.gray_ready = 1'b0;
    bus.done       = 1'b0;
    case (state_q)
      StLoad:  bus.load_ready = 1'b1;
      StServe: bus.gray_ready = 1'b1;
      StDone:  bus.done       = 1'b1;
      default: bus.load_ready = 1'b0;
    endcase
  end

  assign bus.gray_data = gray_data_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.checksum  = checksum_q;
  assign bus.err       = err_q;

endmodule
